// File: rtl/gray_ptr_sync.sv
// Brings a foreign-domain Gray pointer into clk_i and polices its steps.
// Each new synchronised value pulses changed_o; multi-bit steps also raise step_err_o.
module gray_ptr_sync #(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned ERR_CNT_WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [WIDTH-1:0]         gray_async_i,
   input  logic                     clr_err_i,
   output logic [WIDTH-1:0]         gray_sync_o,
   output logic                     changed_o,
   output logic                     step_err_o,
   output logic                     err_sticky_o,
   output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

   localparam int unsigned LAST = SYNC_STAGES - 1;
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0]         sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]         sync_d [SYNC_STAGES];
   logic [WIDTH-1:0]         gray_sync_q, gray_sync_d;
   logic [WIDTH-1:0]         diff;
   logic                     changed_q, changed_d;
   logic                     step_err_q, step_err_d;
   logic                     err_sticky_q, err_sticky_d;
   logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

   // Plain flop chain: only the last stage fans out.
   always_comb begin
      sync_d[0] = gray_async_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   always_comb begin
      gray_sync_d  = sync_q[LAST];
      diff         = sync_q[LAST] ^ gray_sync_q;
      changed_d    = (diff != '0);
      // More than one bit set iff clearing the lowest set bit leaves something.
      step_err_d   = ((diff & (diff - WIDTH'(1))) != '0);
      err_sticky_d = err_sticky_q;
      err_count_d  = err_count_q;
      if (clr_err_i) begin
         err_sticky_d = step_err_d;
         err_count_d  = step_err_d ? ERR_CNT_WIDTH'(1) : '0;
      end else if (step_err_d) begin
         err_sticky_d = 1'b1;
         if (err_count_q != CNT_MAX) begin
            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         gray_sync_q  <= '0;
         changed_q    <= 1'b0;
         step_err_q   <= 1'b0;
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_d[k];
         end
         gray_sync_q  <= gray_sync_d;
         changed_q    <= changed_d;
         step_err_q   <= step_err_d;
         err_sticky_q <= err_sticky_d;
         err_count_q  <= err_count_d;
      end
   end

   assign gray_sync_o  = gray_sync_q;
   assign changed_o    = changed_q;
   assign step_err_o   = step_err_q;
   assign err_sticky_o = err_sticky_q;
   assign err_count_o  = err_count_q;

endmodule

// File: doc/gray_ptr_sync.md
# gray_ptr_sync

Synchronises a Gray-coded pointer from a foreign clock domain into `clk_i` and checks that it stays legal. It sits directly upstream of `gray2bin` in the FIFO pointer path: `gray_sync_o` drives `gray2bin.in_data_i`. It also reports every pointer change and flags any synchronised step that is not a legal single-bit Gray transition. Step errors are kept in a sticky flag and a saturating counter.

## Interface

Parameters:
- `WIDTH`, default 4: pointer width in bits; must be ≥ 2.
- `SYNC_STAGES`, default 2: number of synchroniser flops; must be ≥ 2.
- `ERR_CNT_WIDTH`, default 8: width of the step-error counter.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1: destination-domain clock.
- `rst_i`  in  1: synchronous, active-high reset.
- `gray_async_i`  in  WIDTH: Gray pointer, asynchronous to `clk_i`.
- `clr_err_i`  in  1: clears `err_sticky_o` and `err_count_o`.
- `gray_sync_o`  out  WIDTH: synchronised, registered Gray pointer.
- `changed_o`  out  1: one-cycle pulse when `gray_sync_o` takes a new value.
- `step_err_o`  out  1: one-cycle pulse when that new value differs from the previous one in more than 1 bit.
- `err_sticky_o`  out  1: set by any step error; held until cleared.
- `err_count_o`  out  ERR_CNT_WIDTH: count of step errors; saturates at the maximum value.

## Operation

- Synchroniser: a chain `s[0..SYNC_STAGES-1]`.
  - `s[0] <= gray_async_i`, then `s[k] <= s[k-1]`.
  - No logic between stages; no fan-out from any stage other than the last.
- Output stage, every cycle:
  - `gray_sync_o <= s[last]`.
  - `diff = s[last] ^ gray_sync_o` (current register value).
  - `changed_o <= (diff != 0)`.
  - `step_err_o <= (popcount(diff) > 1)`.
- Flags are aligned with the new `gray_sync_o`: in the cycle where `gray_sync_o` shows a new value, `changed_o` (and `step_err_o` if illegal) are high in that same cycle.
- A step error also updates the error state in that same edge:
  - `err_sticky_o <= 1`.
  - `err_count_o <= err_count_o + 1`, unless the counter is already at `2^ERR_CNT_WIDTH-1`, where it holds (no wrap).
- `clr_err_i`:
  - Alone: sets `err_sticky_o` to 0 and `err_count_o` to 0 at the next edge.
  - Together with a step error in the same edge: the result is `err_sticky_o=1`, `err_count_o=1`. The error is never lost.
- Wrap-around: the transition from the all-max Gray code to 0 (e.g. `1000`→`0000` for WIDTH=4) is a single-bit change and is legal.
- Held input: no pulses; all outputs stable.
- No handshake. The upstream domain guarantees at most one Gray step per source cycle. This block only detects violations; it never corrects them.

## Timing

- Reset (`rst_i=1` at an edge): all synchroniser stages, `gray_sync_o`, `changed_o`, `step_err_o`, `err_sticky_o` and `err_count_o` become 0.
  - Reset has priority over `clr_err_i` and all other activity, including mid-operation.
  - After reset is released, the first captured nonzero pointer is compared against 0. A multi-bit value there raises `step_err_o`.
- Latency: a value stable at `gray_async_i` before edge N is sampled into `s[0]` at edge N. It appears on `gray_sync_o` after edge N+SYNC_STAGES (3 edges for the default).
- `changed_o` and `step_err_o` pulse for exactly one cycle per new value. Back-to-back steps on consecutive cycles give consecutive pulses.
- All outputs are registered. There is no combinational path from input to output.

## Test plan

1. **Reset values.** Assert `rst_i` with `gray_async_i=4'b0110` held → all outputs 0 while reset is held. After release, `gray_sync_o=0110` appears exactly 3 edges later, with `changed_o=1` and `step_err_o=1` (2 bits differ from 0). Then `err_count_o=1`.
2. **Legal sweep.** WIDTH=4: drive the Gray sequence for 0..15 and back to 0, one value per 4 cycles → 16 `changed_o` pulses including the wrap `1000`→`0000`, `step_err_o` never set, `err_count_o=0`, latency 3 on every step.
3. **Illegal jump.** Drive `0001`→`0111` → one `changed_o` pulse plus one `step_err_o` pulse in the same cycle. `err_sticky_o=1`, `err_count_o` increments by 1.
4. **Saturation.** ERR_CNT_WIDTH=2: inject 5 illegal jumps → `err_count_o` reads 1, 2, 3, 3, 3; `err_sticky_o` stays 1.
5. **Clear collision.** Assert `clr_err_i` in the same cycle an illegal step reaches the output stage, with `err_count_o=3` before the edge → `err_count_o=1`, `err_sticky_o=1`. A lone `clr_err_i` on the next cycle → both become 0.
6. **Reset mid-stream.** Assert `rst_i` while a new value is mid-synchroniser → all outputs 0 at the next edge. No `changed_o` pulse for the flushed value while reset is held. Recovery then follows scenario 1.
